// File: rtl/apb_pkg.sv
// Shared definitions for the APB master slice.
//   WIDTH_DEF      default data width of command, bus and response data
//   ADDR_WIDTH_DEF default word address width (128 words)
//   TIMEOUT_DEF    default number of ACCESS cycles allowed before error
//   apb_state_e    transfer state, also exported on the debug port
package apb_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int TIMEOUT_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles of one transfer and flags the last allowed one.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, clears the count
//   clear   restart the count at 0 (new transfer)
//   enable  count this cycle (transfer is in ACCESS)
//   expired high while the current cycle is the TIMEOUT-th counted cycle
module apb_timeout_cnt #(
  parameter int TIMEOUT = apb_pkg::TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // count holds the number of ACCESS cycles already completed, so the
  // cycle in progress is number count+1; saturation only guards misuse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB-style master: takes a command over a valid/ready
// port, runs SETUP then ACCESS on the bus, and returns the result over a
// valid/ready response port. A transfer whose responder never answers is
// closed after TIMEOUT ACCESS cycles with rsp_err_o set.
//
// Handshakes: a transfer on either the command or the response port happens
// on a rising edge where valid and ready are both high; the side asserting
// valid keeps it and its payload steady until that edge.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cmd_*               command request (write flag, word address, data)
//   sel_o, valid_o      bus select and access-phase strobe
//   wr_rd_o, addr_o,
//   wdata_o             bus fields, held for the whole transfer
//   ready_i, rdata_i    responder completion and read data
//   rsp_*               response (read data, timeout error)
//   state_o             current transfer state, for debug/checkers
module apb_master
  import apb_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WIDTH-1:0]      cmd_wdata_i,
  output logic                  sel_o,
  output logic                  valid_o,
  output logic                  wr_rd_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_rdata_o,
  output logic                  rsp_err_o,
  output apb_state_e            state_o
);

  apb_state_e            state;
  apb_state_e            state_next;
  logic                  run;
  logic                  accept;
  logic                  expired;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic [WIDTH-1:0]      rsp_rdata_q;
  logic                  rsp_err_q;

  // run keeps cmd_ready_o low while reset is asserted and rises on the
  // first clock after release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign accept = (state == ST_IDLE) && run && cmd_valid_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (accept) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      // ready_i wins over expiry on the last allowed cycle.
      ST_ACCESS: if (ready_i || expired) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic; bus and response fields read as 0 when not in use.
  always_comb begin
    cmd_ready_o = (state == ST_IDLE) && run;
    sel_o       = (state == ST_SETUP) || (state == ST_ACCESS);
    valid_o     = (state == ST_ACCESS);
    wr_rd_o     = sel_o ? write_q : 1'b0;
    addr_o      = sel_o ? addr_q  : '0;
    wdata_o     = sel_o ? wdata_q : '0;
    rsp_valid_o = (state == ST_RESP);
    rsp_rdata_o = rsp_valid_o ? rsp_rdata_q : '0;
    rsp_err_o   = rsp_valid_o ? rsp_err_q   : 1'b0;
    state_o     = state;
  end

  // Command capture and response capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= cmd_write_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
      end
      if (state == ST_ACCESS) begin
        if (ready_i) begin
          rsp_rdata_q <= write_q ? '0 : rdata_i;
          rsp_err_q   <= 1'b0;
        end else if (expired) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
    end
  end

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clear   (accept),
    .enable  (state == ST_ACCESS),
    .expired (expired)
  );

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;
  import apb_pkg::*;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 7;
  localparam int TIMEOUT    = 16;

  logic                  clk_i;
  logic                  rst_i;
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [WIDTH-1:0]      cmd_wdata_i;
  logic                  sel_o;
  logic                  valid_o;
  logic                  wr_rd_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [WIDTH-1:0]      wdata_o;
  logic                  ready_i;
  logic [WIDTH-1:0]      rdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [WIDTH-1:0]      rsp_rdata_o;
  logic                  rsp_err_o;
  apb_state_e            state_o;

  apb_master #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .sel_o       (sel_o),
    .valid_o     (valid_o),
    .wr_rd_o     (wr_rd_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .ready_i     (ready_i),
    .rdata_i     (rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH:0]   exp_q[$];            // {err, rdata} per issued command
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];  // responder memory

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Issues one command and plays the responder: ready_i is raised on ACCESS
  // cycle ready_cycle (0 = never). lat is counted in rising edges after the
  // accepting edge until rsp_valid_o is seen; acc counts ACCESS cycles.
  task automatic do_cmd(input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [WIDTH-1:0] wdata, input int ready_cycle,
                        input int hold, input logic [WIDTH-1:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_acc);
    int k;
    int lat;
    bit got;
    logic [WIDTH:0] exp;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk_i);
    check("idle_cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    @(negedge clk_i);
    // SETUP: command inputs now ignored, ready_i must be ignored too
    cmd_valid_i = 1'b0;
    cmd_addr_i  = ADDR_WIDTH'($urandom);
    cmd_wdata_i = $urandom;
    cmd_write_i = ~wr;
    check("setup_state", state_o, ST_SETUP);
    check("setup_sel", sel_o, 1);
    check("setup_valid", valid_o, 0);
    check("setup_wr_rd", wr_rd_o, wr);
    check("setup_addr", addr_o, addr);
    check("setup_wdata", wdata_o, wdata);
    check("setup_cmd_ready", cmd_ready_o, 0);
    ready_i = 1'b1;
    k   = 0;
    lat = 0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk_i);
      lat++;
      ready_i = 1'b0;
      rdata_i = $urandom;
      if (rsp_valid_o) begin
        got = 1;
      end else if (valid_o) begin
        k++;
        check("access_sel", sel_o, 1);
        check("access_addr", addr_o, addr);
        check("access_wr_rd", wr_rd_o, wr);
        check("access_wdata", wdata_o, wdata);
        if (k == ready_cycle) begin
          ready_i = 1'b1;
          if (wr) mem[addr] = wdata;
          else    rdata_i = mem[addr];
        end
      end
    end
    exp = exp_q.pop_front();
    check("rsp_seen", got, 1);
    check("rsp_latency", lat, exp_lat);
    check("access_cycles", k, exp_acc);
    check("rsp_rdata", rsp_rdata_o, exp[WIDTH-1:0]);
    check("rsp_err", rsp_err_o, exp[WIDTH]);
    check("rsp_sel_low", sel_o, 0);
    check("rsp_valid_low", valid_o, 0);
    check("rsp_cmd_ready", cmd_ready_o, 0);
    check("rsp_state", state_o, ST_RESP);
    for (int h = 0; h < hold; h++) begin
      cmd_valid_i = 1'b1;
      ready_i     = 1'b1;
      @(negedge clk_i);
      check("hold_rsp_valid", rsp_valid_o, 1);
      check("hold_rdata", rsp_rdata_o, exp[WIDTH-1:0]);
      check("hold_err", rsp_err_o, exp[WIDTH]);
      check("hold_cmd_ready", cmd_ready_o, 0);
    end
    cmd_valid_i = 1'b0;
    ready_i     = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("done_rsp_valid", rsp_valid_o, 0);
    check("done_state", state_o, ST_IDLE);
    check("done_cmd_ready", cmd_ready_o, 1);
  endtask

  // Starts a read that is never answered and resets during ACCESS.
  task automatic reset_mid_access();
    int seen;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b0;
    cmd_addr_i  = 7'h10;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_reset_access", state_o, ST_ACCESS);
    rst_i = 1'b0;
    #1;
    check("reset_state", state_o, ST_IDLE);
    check("reset_sel", sel_o, 0);
    check("reset_valid", valid_o, 0);
    check("reset_rsp_valid", rsp_valid_o, 0);
    check("reset_cmd_ready", cmd_ready_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o || sel_o) seen++;
    end
    check("no_rsp_after_reset", seen, 0);
    check("post_reset_cmd_ready", cmd_ready_o, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    ready_i     = 1'b0;
    rdata_i     = '0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] = '0;
    mem[7'h10] = 32'hA5A5A5A5;
    mem[7'h22] = 32'h12345678;

    repeat (2) @(negedge clk_i);
    check("rst_state", state_o, ST_IDLE);
    check("rst_cmd_ready", cmd_ready_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rel_cmd_ready", cmd_ready_o, 1);

    // ready_i while idle must not start anything
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("idle_ready_ignored", state_o, ST_IDLE);

    //      wr    addr   wdata          rdy hold exp_rdata      err lat acc
    do_cmd(1'b1, 7'h05, 32'hDEADBEEF,   2,  0, 32'h00000000, 1'b0,  3,  2);
    do_cmd(1'b0, 7'h05, 32'h00000000,   2,  0, 32'hDEADBEEF, 1'b0,  3,  2);
    do_cmd(1'b0, 7'h10, 32'h00000000,   0,  0, 32'h00000000, 1'b1, 17, 16);
    do_cmd(1'b0, 7'h22, 32'h00000000,  16,  0, 32'h12345678, 1'b0, 17, 16);
    do_cmd(1'b1, 7'h33, 32'h0BADF00D,   1,  5, 32'h00000000, 1'b0,  2,  1);
    do_cmd(1'b0, 7'h33, 32'h00000000,   3,  2, 32'h0BADF00D, 1'b0,  4,  3);
    do_cmd(1'b1, 7'h7F, 32'hCAFEF00D,  15,  0, 32'h00000000, 1'b0, 16, 15);

    reset_mid_access();

    do_cmd(1'b0, 7'h7F, 32'h00000000,   1,  0, 32'hCAFEF00D, 1'b0,  2,  1);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter WIDTH, 32, data width of command, APB and response data.
REQ-002 Parameter ADDR_WIDTH, 7, word address width (4096-bit memory / 32 = 128 words).
REQ-003 Parameter TIMEOUT, 16, max ACCESS cycles waiting for ready_i before error.
REQ-004 Port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 Port cmd_valid_i  input  1  command request.
REQ-007 Port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-008 Port cmd_write_i  input  1  1 = write, 0 = read.
REQ-009 Port cmd_addr_i  input  ADDR_WIDTH  command word address.
REQ-010 Port cmd_wdata_i  input  WIDTH  command write data.
REQ-011 Port sel_o  output  1  peripheral select.
REQ-012 Port valid_o  output  1  access-phase strobe (to the responder's valid_i).
REQ-013 Port wr_rd_o  output  1  1 = write, 0 = read.
REQ-014 Port addr_o  output  ADDR_WIDTH  bus address.
REQ-015 Port wdata_o  output  WIDTH  bus write data.
REQ-016 Port ready_i  input  1  responder completion.
REQ-017 Port rdata_i  input  WIDTH  responder read data, valid when ready_i=1.
REQ-018 Port rsp_valid_o  output  1  response available.
REQ-019 Port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-020 Port rsp_rdata_o  output  WIDTH  read data (0 for writes and errors).
REQ-021 Port rsp_err_o  output  1  1 = transfer timed out.

Function
REQ-022 FSM states: IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-023 IDLE: cmd_ready_o=1; on cmd_valid_i=1, latch write/addr/wdata -> SETUP next cycle.
REQ-024 SETUP (exactly 1 cycle): sel_o=1, valid_o=0, addr_o/wr_rd_o/wdata_o driven from latched command -> ACCESS.
REQ-025 ACCESS: sel_o=1, valid_o=1, bus fields held stable; timeout counter increments each cycle.
REQ-026 ACCESS with ready_i=1: capture rdata_i if read (0 if write), rsp_err_o=0 -> RESP; sel_o/valid_o drop next cycle.
REQ-027 ACCESS without ready_i for TIMEOUT consecutive cycles: rsp_rdata_o=0, rsp_err_o=1 -> RESP.
REQ-028 ready_i=1 on the TIMEOUT-th cycle counts as success, not error.
REQ-029 RESP: rsp_valid_o=1, rsp_rdata_o/rsp_err_o stable; sel_o=0, valid_o=0; on rsp_ready_i=1 -> IDLE.
REQ-030 Minimum latency: command accept to rsp_valid_o = 3 cycles with ready_i returned 1 cycle into ACCESS.
REQ-031 cmd_ready_o=0 in all states except IDLE; back-to-back commands separated by at least one IDLE cycle.
REQ-032 ready_i ignored outside ACCESS; cmd inputs ignored outside IDLE.
REQ-033 Timeout counter cleared on entry to SETUP; width $clog2(TIMEOUT+1).

Reset
REQ-034 rst_i=0 asynchronously forces IDLE, all outputs 0 except cmd_ready_o (1 after release), counter 0.
REQ-035 Reset mid-transfer aborts it; no response is produced for the aborted command.

Structure
REQ-036 Shared package apb_pkg holds WIDTH, ADDR_WIDTH defaults and the state enumeration.
REQ-037 One sub-module apb_timeout_cnt (clear, enable, expired output); rest is in apb_master.

Verification
REQ-038 Write addr 0x05 data 0xDEADBEEF, ready_i after 1 ACCESS cycle -> wr_rd_o=1, rsp_valid_o 3 cycles after accept, rsp_err_o=0, rsp_rdata_o=0.
REQ-039 Read addr 0x05 against apb_memory after REQ-038 write -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
REQ-040 Read with ready_i held 0 -> after 16 ACCESS cycles rsp_err_o=1, rsp_rdata_o=0, sel_o drops.
REQ-041 ready_i=1 exactly on 16th ACCESS cycle, rdata_i=0x12345678 -> rsp_err_o=0, rsp_rdata_o=0x12345678.
REQ-042 rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and data stable, cmd_ready_o=0 throughout.
REQ-043 rst_i pulsed low during ACCESS -> immediate IDLE, sel_o=valid_o=rsp_valid_o=0, no response after release.
